// File: rtl/gen_pkg.sv
// Shared constants, FSM state type and the offset-binary attenuation helper
// for the wave sequencer.
package gen_pkg;

    localparam int          DATA_W    = 12;
    localparam int          ADDR_W    = 12;
    localparam logic [11:0] MIDSCALE  = 12'h800;
    localparam logic [3:0]  ATTEN_MAX = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        CAPT,
        HOLD
    } state_e;

    // Shift the signed distance from midscale, then re-centre.
    // A 13-bit difference cannot overflow, so the result always fits 12 bits.
    function automatic logic [DATA_W-1:0] attenuate(input logic [DATA_W-1:0] sample,
                                                    input logic [3:0]        atten);
        logic [3:0]               sh;
        logic signed [DATA_W:0]   diff;
        logic signed [DATA_W:0]   shifted;
        sh      = (atten > ATTEN_MAX) ? ATTEN_MAX : atten;
        diff    = $signed({1'b0, sample}) - $signed({1'b0, MIDSCALE});
        shifted = diff >>> sh;
        return MIDSCALE + shifted[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/phase_accumulator.sv
// Phase register, latched tuning word and deferred phase-clear flag.
// addr_nxt_o exposes the table index of the phase value taking effect at the next edge.
module phase_accumulator #(
    parameter int PHASE_W    = 24,
    parameter int TABLE_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PHASE_W-1:0]    step_i,
    input  logic                  load_step_i,
    input  logic                  advance_i,
    input  logic                  clr_i,
    input  logic                  idle_i,
    output logic [TABLE_BITS-1:0] addr_nxt_o
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] step_q, step_d;
    logic               clr_pend_q, clr_pend_d;

    always_comb begin
        phase_d    = phase_q;
        step_d     = step_q;
        clr_pend_d = clr_pend_q;
        if (advance_i) begin
            // Clear wins over the increment, whether pending or arriving now.
            phase_d    = (clr_i || clr_pend_q) ? '0 : phase_q + step_q;
            clr_pend_d = 1'b0;
        end else if (idle_i) begin
            if (clr_i) begin
                phase_d = '0;
            end
            clr_pend_d = 1'b0;
        end else if (clr_i) begin
            clr_pend_d = 1'b1;
        end
        if (load_step_i) begin
            step_d = step_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= '0;
            step_q     <= '0;
            clr_pend_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            step_q     <= step_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    assign addr_nxt_o = phase_d[PHASE_W-1 -: TABLE_BITS];

endmodule

// File: rtl/wave_sequencer.sv
// Sample-memory read initiator: phase-driven table addressing, attenuation,
// and valid/ready delivery to the DAC stage.
//
// state | meaning
// IDLE  | waiting for enable; phase_clr acts immediately
// ADDR  | mem_address presented, memory captures it at the closing edge
// CAPT  | mem_sample valid, attenuated result registered
// HOLD  | sample_valid high until sample_ready handshake
module wave_sequencer
    import gen_pkg::*;
#(
    parameter int PHASE_W    = 24,
    parameter int TABLE_BITS = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [PHASE_W-1:0] step,
    input  logic               phase_clr,
    input  logic [3:0]         atten,
    output logic [ADDR_W-1:0]  mem_address,
    input  logic [DATA_W-1:0]  mem_sample,
    output logic [DATA_W-1:0]  sample_out,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               busy
);

    localparam int ADDR_PAD = ADDR_W - TABLE_BITS;

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       sample_q, sample_d;
    logic                    valid_q, valid_d;
    logic                    advance;
    logic                    load_step;
    logic [TABLE_BITS-1:0]   addr_nxt;

    // Kept outside the FSM block so the accumulator feedback stays acyclic.
    assign advance   = (state_q == HOLD) && sample_ready;
    assign load_step = enable && ((state_q == IDLE) || advance);

    phase_accumulator #(
        .PHASE_W    (PHASE_W),
        .TABLE_BITS (TABLE_BITS)
    ) u_phase (
        .clk         (clk),
        .rst         (rst),
        .step_i      (step),
        .load_step_i (load_step),
        .advance_i   (advance),
        .clr_i       (phase_clr),
        .idle_i      (state_q == IDLE),
        .addr_nxt_o  (addr_nxt)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        sample_d = sample_q;
        valid_d  = valid_q;
        if (load_step) begin
            addr_d = {{ADDR_PAD{1'b0}}, addr_nxt};
        end
        case (state_q)
            IDLE: if (enable) state_d = ADDR;
            ADDR: state_d = CAPT;
            CAPT: begin
                sample_d = attenuate(mem_sample, atten);
                valid_d  = 1'b1;
                state_d  = HOLD;
            end
            HOLD: if (sample_ready) begin
                valid_d = 1'b0;
                state_d = enable ? ADDR : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign mem_address  = addr_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_wave_sequencer.sv
// Self-checking bench for wave_sequencer: scoreboard of expected
// (address, sample) pairs checked at every handshake, plus directed corner cases.
module tb_wave_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [23:0] step = '0;
    logic        phase_clr = 1'b0;
    logic [3:0]  atten = '0;
    logic [11:0] mem_address;
    logic [11:0] mem_sample;
    logic [11:0] sample_out;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    wave_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .step         (step),
        .phase_clr    (phase_clr),
        .atten        (atten),
        .mem_address  (mem_address),
        .mem_sample   (mem_sample),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy)
    );

    // Memory model: entry i = i*0x080, one-cycle registered read.
    always @(posedge clk) mem_sample <= {mem_address[4:0], 7'b0};

    typedef struct {
        logic [11:0] addr;
        logic [11:0] data;
    } exp_t;

    typedef struct {
        logic [4:0]  addr;
        logic [3:0]  att;
        logic [11:0] exp_data;
    } vec_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Floor-division model of the arithmetic shift about midscale.
    function automatic logic [11:0] model_att(input logic [11:0] s, input logic [3:0] a);
        int sh;
        int d;
        int q;
        sh = (a > 4'd11) ? 11 : int'(a);
        d  = int'(s) - 2048;
        if (d >= 0) q = d / (1 << sh);
        else        q = -((-d + (1 << sh) - 1) / (1 << sh));
        return 12'(2048 + q);
    endfunction

    task automatic push(input int addr, input logic [3:0] a);
        exp_t e;
        e.addr = 12'(addr);
        e.data = model_att({e.addr[4:0], 7'b0}, a);
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && sample_valid && sample_ready) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_sample: got addr %0h data %0h, required none", mem_address, sample_out);
            end else begin
                e = sb_q.pop_front();
                check("sb_addr", 32'(mem_address), 32'(e.addr));
                check("sb_data", 32'(sample_out), 32'(e.data));
            end
        end
    end

    task automatic do_reset();
        rst          = 1'b1;
        enable       = 1'b0;
        phase_clr    = 1'b0;
        sample_ready = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Runs until the scoreboard drains and the DUT is idle; drops enable once
    // the last expected sample is in flight.
    task automatic run_drain(input int budget, input int clr_addr,
                             output int first_valid, output int period);
        int  cyc  = 0;
        int  last = -1;
        int  arm  = 0;
        bit  prev = 1'b0;
        bit  done = 1'b0;
        first_valid = -1;
        period      = -1;
        enable      = 1'b1;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (sample_valid && !prev) begin
                if (first_valid < 0) first_valid = cyc;
                else if (period < 0) period = cyc - last;
                last = cyc;
            end
            prev      = sample_valid;
            phase_clr = (arm == 1);
            if (arm == 1) arm = 2;
            if (arm == 0 && clr_addr >= 0 && busy && !sample_valid && mem_address == clr_addr[11:0])
                arm = 1;
            if (sb_q.size() <= 1) enable = 1'b0;
            if (sb_q.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_timeout: got %0d samples outstanding, required 0", sb_q.size());
            sb_q.delete();
            enable    = 1'b0;
            phase_clr = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        int   fv;
        int   per;
        bit   seen;

        vecs[0]  = '{5'd0,  4'd1,  12'h400};
        vecs[1]  = '{5'd31, 4'd2,  12'h9E0};
        vecs[2]  = '{5'd31, 4'd0,  12'hF80};
        vecs[3]  = '{5'd1,  4'd0,  12'h080};
        vecs[4]  = '{5'd0,  4'd15, 12'h7FF};
        vecs[5]  = '{5'd0,  4'd11, 12'h7FF};
        vecs[6]  = '{5'd31, 4'd15, 12'h800};
        vecs[7]  = '{5'd16, 4'd3,  12'h800};
        vecs[8]  = '{5'd8,  4'd4,  12'h7C0};
        vecs[9]  = '{5'd24, 4'd1,  12'hA00};
        vecs[10] = '{5'd17, 4'd12, 12'h800};
        vecs[11] = '{5'd15, 4'd5,  12'h7FC};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr",   32'(mem_address), 32'h000);
        check("rst_sample", 32'(sample_out),  32'h000);
        check("rst_valid",  32'(sample_valid), 32'h0);
        check("rst_busy",   32'(busy),        32'h0);
        rst = 1'b0;

        // Basic run: addresses 0..31 then wrap to 0
        do_reset();
        step = 24'h080000; atten = 4'd0; sample_ready = 1'b1;
        for (int i = 0; i <= 32; i++) push(i % 32, 4'd0);
        run_drain(400, -1, fv, per);
        check("first_valid_latency", 32'(fv), 32'd3);
        check("throughput_period",   32'(per), 32'd3);
        check("basic_idle", 32'(busy), 32'h0);

        // Attenuation table
        for (int v = 0; v < 12; v++) begin
            do_reset();
            atten = vecs[v].att;
            step  = {vecs[v].addr, 19'b0};
            sample_ready = 1'b1;
            push(0, vecs[v].att);
            sb_q.push_back('{{7'b0, vecs[v].addr}, vecs[v].exp_data});
            run_drain(60, -1, fv, per);
        end

        // Backpressure: ten stalled cycles, then release
        do_reset();
        step = 24'h080000; atten = 4'd0; sample_ready = 1'b0;
        push(0, 4'd0);
        push(1, 4'd0);
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = sample_valid;
        end
        check("bp_valid_seen", 32'(seen), 32'h1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_stable", {19'b0, sample_valid, mem_address}, {19'b0, 1'b1, 12'h000});
            check("bp_sample", 32'(sample_out), 32'h000);
        end
        sample_ready = 1'b1;
        run_drain(60, -1, fv, per);

        // phase_clr asserted in CAPT at address 7
        do_reset();
        step = 24'h080000; atten = 4'd0; sample_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(i, 4'd0);
        push(0, 4'd0);
        push(1, 4'd0);
        run_drain(200, 7, fv, per);

        // Enable dropped in ADDR: one sample then idle
        do_reset();
        step = 24'h080000; sample_ready = 1'b1;
        push(0, 4'd0);
        run_drain(40, -1, fv, per);
        repeat (4) @(posedge clk);
        #1;
        check("disable_idle", {30'b0, busy, sample_valid}, 32'h0);

        // Reset asserted in HOLD
        do_reset();
        step = 24'h080000; sample_ready = 1'b1;
        push(0, 4'd0);
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) sample_ready = 1'b0;
            seen = sample_valid && !sample_ready && mem_address == 12'h001;
        end
        check("hold_reached", 32'(seen), 32'h1);
        check("hold_sample",  32'(sample_out), 32'h080);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid",  32'(sample_valid), 32'h0);
        check("midrst_addr",   32'(mem_address),  32'h000);
        check("midrst_sample", 32'(sample_out),   32'h000);
        check("midrst_busy",   32'(busy),         32'h0);
        enable = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Backward wrap, DC at a nonzero phase, then clear in IDLE and DC at 0
        do_reset();
        step = 24'hF80000; atten = 4'd0; sample_ready = 1'b1;
        push(0, 4'd0); push(31, 4'd0); push(30, 4'd0); push(29, 4'd0); push(28, 4'd0);
        run_drain(100, -1, fv, per);
        step = 24'h000000;
        for (int i = 0; i < 3; i++) push(27, 4'd0);
        run_drain(60, -1, fv, per);
        phase_clr = 1'b1;
        @(posedge clk);
        #1 phase_clr = 1'b0;
        for (int i = 0; i < 3; i++) push(0, 4'd0);
        run_drain(60, -1, fv, per);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wave_sequencer.md
Name: wave_sequencer

Overview:
- Initiator side of the 12-bit sample-memory read interface.
- Runs a phase accumulator and turns its top bits into table addresses.
- Issues each address to the sample memory and captures the returned 12-bit sample one clock later.
- Applies offset-binary attenuation and delivers the result to the downstream DAC stage over a valid/ready handshake.

Parameters:
- PHASE_W, 24, phase accumulator / tuning word width.
- TABLE_BITS, 5, log2 of table entries used (32); addresses span 0..2^TABLE_BITS-1.
- DATA_W, 12, sample width; fixed by the memory interface.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  run request; sampled only in IDLE and at handshake.
- step  in  PHASE_W  tuning word; latched at each handshake and on leaving IDLE.
- phase_clr  in  1  synchronous clear of the phase accumulator.
- atten  in  4  attenuation shift 0..11; values >11 treated as 11.
- mem_address  out  12  address to sample memory, registered.
- mem_sample  in  12  memory data, valid the cycle after mem_address is presented.
- sample_out  out  DATA_W  attenuated sample to DAC stage.
- sample_valid  out  1  sample_out holds a new sample.
- sample_ready  in  1  downstream accepts; transfer when valid and ready at the same edge.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: phase=0, step_q=0, mem_address=12'h000, sample_out=12'h000, sample_valid=0, busy=0, state=IDLE.
- Reset is honoured mid-operation in any state; it drops valid immediately.
- Address formation: mem_address = zero-extend(phase[PHASE_W-1 -: TABLE_BITS]) to 12 bits.
- Phase arithmetic: phase wraps modulo 2^PHASE_W with no saturation.

State machine:
- IDLE: if enable, latch step into step_q and load mem_address from phase, then go to ADDR.
- ADDR: one cycle; memory captures mem_address at the closing edge. Go to CAPT.
- CAPT: at the closing edge:
  - register sample_out = attenuate(mem_sample);
  - set sample_valid=1;
  - go to HOLD.
- HOLD: hold sample_out and sample_valid stable until sample_ready=1. On the handshake edge:
  - phase <= phase + step_q, or 0 if phase_clr is high;
  - sample_valid <= 0;
  - if enable: latch step and load mem_address from the new phase, go to ADDR;
  - else go to IDLE.

Timing and throughput:
- Latency is 2 clocks from entering ADDR to sample_valid high.
- Throughput is 1 sample per 3 clocks with ready held high.
- sample_valid never deasserts without a handshake. Dropping enable mid-flight completes the current sample.

phase_clr:
- In IDLE: clears phase at the next edge.
- In ADDR/CAPT/HOLD before the handshake: registered as pending, applied at the handshake.
- Clear wins over the increment.

Attenuation:
- d = signed(mem_sample - 12'h800), 13-bit.
- result = 12'h800 + (d >>> atten), arithmetic shift.
- atten=0 passes data unchanged.
- Result always lies in 0..FFF; no clipping is needed.

Boundary conditions:
- step=0: the same address repeats (DC output).
- step >= 2^PHASE_W/2: aliases backwards; legal, no special handling.
- Phase crossing 2^PHASE_W wraps the address to 0.

Decomposition:
- Shared package gen_pkg holds:
  - DATA_W=12, MIDSCALE=12'h800, ADDR_W=12;
  - state enum {IDLE, ADDR, CAPT, HOLD}.
- Sub-module phase_accumulator contains:
  - the PHASE_W register, step_q latch and pending-clear flag;
  - inputs: load_step, advance, clr.

Test Plan:
- Bench memory model: entry i = i*12'h080, 1-cycle registered latency.
- Basic run: step=24'h080000, atten=0, ready=1 -> mem_address sequence 0,1,2,...,31,0. Samples 000,080,100,... with valid every 3rd clock; first valid 3 clocks after enable rises.
- Backpressure: ready=0 for 10 clocks while valid -> sample_out/valid stable, phase unchanged. Address advances only after ready=1.
- Attenuation: address 0 (sample 000), atten=1 -> 12'h400. Address 31 (F80), atten=2 -> 12'h9E0. atten=15 behaves as 11.
- phase_clr mid-flight: assert in CAPT at address 7 -> the next address after the handshake is 0, not 8.
- Disable/reset: enable dropped in ADDR -> one more sample delivered, then IDLE with busy=0. rst pulsed in HOLD -> valid=0, mem_address=0, sample_out=0 the same cycle.
- Wrap: step=24'hF80000 -> addresses 0,31,30,...; step=0 -> address 0 repeated indefinitely.
